axi4_lite_reg_slave: RTL
========================

# axi4_lite_reg_slave

AXI4-Lite slave front-end that converts bus transactions into the single-cycle register-file access strobes (write_en/write_addr/write_data, read_addr/read_data). Sits directly upstream of the GPIO/PWM register file. It buffers independently arriving AW and W beats, serialises each write into a one-cycle strobe, registers read data, and applies B/R channel backpressure. One outstanding write and one outstanding read at a time; the read and write paths are independent.

## Interface
- ADDR_WIDTH, 4, register address width; AXI address bits pass through unchanged as register addresses
- DATA_WIDTH, 32, data width; WSTRB width is DATA_WIDTH/8
- clk  in  1  single clock; all state changes on posedge
- rst_n  in  1  reset, synchronous, active-low
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake
- s_axi_bresp  out  2  00 OKAY, 10 SLVERR
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  2  always 00
- write_en  out  1  one-cycle register-file write strobe
- write_addr  out  ADDR_WIDTH  registered write address
- write_data  out  DATA_WIDTH  registered write data
- read_addr  out  ADDR_WIDTH  register-file read address (combinational from s_axi_araddr)
- read_data  in  DATA_WIDTH  combinational register-file read data

## Operation
- Write state: aw_held, w_held, held address, data and strobe registers, and bvalid.
- awready = !aw_held; wready = !w_held. An AW or W handshake sets the matching held flag and captures the payload. AW and W may arrive in either order or in the same cycle.
- Commit condition: aw_held && w_held && !bvalid.
  - On commit, write_en = 1 if wstrb == all ones; otherwise write_en = 0 (write suppressed).
  - On the commit edge: both held flags clear, bvalid sets, bresp = 00 for a full-strobe write and 10 for a partial one.
- write_en is combinational from held state, so it is high for exactly one cycle per committed full-strobe write. write_addr and write_data come from the held registers.
- While bvalid is high and bready is low, no further commit occurs. New AW/W beats may still be captured into empty held slots.
- A B handshake (bvalid && bready) clears bvalid.
- Read path:
  - arready = !rvalid || rready.
  - read_addr = s_axi_araddr.
  - On an AR handshake, rdata <= read_data and rvalid sets.
  - On an R handshake with no new AR handshake in the same cycle, rvalid clears.
- Unmapped read addresses return whatever the register file supplies (DEADBEEF); rresp stays OKAY.
- Reset values: awready = 1, wready = 1, arready = 1, bvalid = 0, rvalid = 0, bresp = 00, rresp = 00, rdata = 0, write_en = 0, write_addr = 0, write_data = 0. All held flags clear.
- Reset asserted mid-transaction discards held beats and any pending B/R response, with no write strobe issued.

## Timing
- Write: with AW and W handshakes on edge N, write_en is high in cycle N+1 and bvalid is high from cycle N+2.
- Write with split arrival: latency is counted from the later of the two handshakes.
- Back-to-back writes with bready tied high: one write per 2 cycles.
- Read: AR handshake on edge N gives rvalid and rdata valid from cycle N+1. With rready tied high, reads sustain one per cycle.
- A read and a write to the same address in the same cycle: the read returns the pre-write value.
- Outputs are stable while valid && !ready (rdata, bresp).

## Test plan
- Reset, then AW+W in the same cycle: addr GPIO_OUT_ADDR, data 0x000000A5, wstrb 0xF -> write_en for one cycle with write_data 0x000000A5; bvalid 2 cycles after the handshake, bresp 00; a later read of GPIO_OUT_ADDR returns 0x000000A5.
- W three cycles before AW (PWM_PERIOD_ADDR, 0x00000100) -> wready low after the W capture; write_en one cycle after the AW handshake; exactly one strobe.
- Partial strobe (wstrb 0x3, PWM_CTRL_ADDR, 0x12345678) -> no write_en; bresp 10; a read of PWM_CTRL_ADDR returns the previous value.
- bready held low for 5 cycles after a write, with a second AW/W presented -> second beats captured, awready/wready then low, no second write_en until one cycle after the first B handshake.
- Back-to-back reads with rready high: GPIO_IN_ADDR (gpio_in = 0x3C) then an unmapped address -> rdata 0x0000003C then 0xDEADBEEF on consecutive cycles; rresp 00.
- rst_n low for one cycle while aw_held is set and bvalid is high -> all valids low and readies high next cycle; no write_en issued.

Source files
------------

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave front-end that turns bus writes into one-cycle register-file
// write strobes and bus reads into registered register-file reads.
//
// Ports:
//   clk, rst_n          single clock, synchronous active-low reset
//   s_axi_aw*           write-address channel (valid/ready/addr)
//   s_axi_w*            write-data channel (valid/ready/data/strb)
//   s_axi_b*            write-response channel (valid/ready/resp)
//   s_axi_ar*           read-address channel (valid/ready/addr)
//   s_axi_r*            read-data channel (valid/ready/data/resp)
//   write_en            one-cycle register-file write strobe
//   write_addr/data     held write address and data for the strobe
//   read_addr           register-file read address (follows s_axi_araddr)
//   read_data           combinational register-file read data
module axi4_lite_reg_slave #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,

    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,

    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [1:0]              s_axi_bresp,

    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,

    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,

    output logic                    write_en,
    output logic [ADDR_WIDTH-1:0]   write_addr,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [ADDR_WIDTH-1:0]   read_addr,
    input  logic [DATA_WIDTH-1:0]   read_data
);

    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic commit;
    logic full_strb;

    assign aw_hs = s_axi_awvalid && !aw_held;
    assign w_hs  = s_axi_wvalid && !w_held;
    assign b_hs  = bvalid_q && s_axi_bready;

    // A commit needs both beats and a free B slot; a stalled response
    // blocks the next commit but not the capture of new beats.
    assign commit    = aw_held && w_held && !bvalid_q;
    assign full_strb = (w_strb_q == {STRB_W{1'b1}});

    // Partial-strobe writes are refused: no strobe, SLVERR response.
    assign write_en   = commit && full_strb;
    assign write_addr = aw_addr_q;
    assign write_data = w_data_q;

    assign s_axi_awready = !aw_held;
    assign s_axi_wready  = !w_held;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;

    // Held flags cannot see a handshake and a commit in the same cycle:
    // a commit needs both flags set, which closes both ready signals.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axi_awaddr;
            end

            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end

            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= full_strb ? RESP_OKAY : RESP_SLVERR;
            end else if (b_hs) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ar_hs;
    logic                  r_hs;

    // The R slot can be refilled in the cycle it drains, so reads
    // stream at one per cycle while rready stays high.
    assign s_axi_arready = !rvalid_q || s_axi_rready;
    assign ar_hs         = s_axi_arvalid && s_axi_arready;
    assign r_hs          = rvalid_q && s_axi_rready;

    assign read_addr    = s_axi_araddr;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = RESP_OKAY;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= read_data;
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule
